// File: rtl/id_stage_reg.sv
// IF/ID pipeline register: holds the fetched instruction and PC behind a
// valid/ready handshake and registers the primary opcode decode.
module id_stage_reg #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] instr_q,
  output logic [24:0]     imm,
  output logic [2:0]      immsrc,
  output logic            imm_used,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic            illegal
);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_U = 3'b010;
  localparam logic [2:0] IMM_B = 3'b101;
  localparam logic [2:0] IMM_J = 3'b110;

  // Returns {illegal, imm_used, immsrc} for a major opcode.
  function automatic logic [4:0] decode_op(input logic [6:0] op);
    logic [4:0] d;
    case (op)
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b1110011: d = {1'b0, 1'b1, IMM_I};
      7'b0100011:             d = {1'b0, 1'b1, IMM_S};
      7'b1100011:             d = {1'b0, 1'b1, IMM_B};
      7'b0110111, 7'b0010111: d = {1'b0, 1'b1, IMM_U};
      7'b1101111:             d = {1'b0, 1'b1, IMM_J};
      7'b0110011, 7'b0001111: d = {1'b0, 1'b0, IMM_I};
      default:                d = {1'b1, 1'b0, IMM_I};
    endcase
    return d;
  endfunction

  logic            out_valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] instr_r;
  logic [2:0]      immsrc_r;
  logic            imm_used_r;
  logic            illegal_r;
  logic            load_s;
  logic [4:0]      dec_s;

  assign in_ready = !out_valid_r || out_ready;
  assign load_s   = in_valid && in_ready && !flush;
  assign dec_s    = decode_op(in_instr[6:0]);

  // Pipeline state: flush beats load, load beats consume, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      pc_r        <= RESET_PC;
      instr_r     <= {XLEN{1'b0}};
      immsrc_r    <= 3'b000;
      imm_used_r  <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      pc_r        <= in_pc;
      instr_r     <= in_instr;
      illegal_r   <= dec_s[4];
      imm_used_r  <= dec_s[3];
      immsrc_r    <= dec_s[2:0];
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign pc_q      = pc_r;
  assign instr_q   = instr_r;
  assign immsrc    = immsrc_r;
  assign imm_used  = imm_used_r;
  assign illegal   = illegal_r;
  // Field slices of the held word; sign extension is left to the extender.
  assign imm       = instr_r[31:7];
  assign rd        = instr_r[11:7];
  assign rs1       = instr_r[19:15];
  assign rs2       = instr_r[24:20];
  assign funct3    = instr_r[14:12];

endmodule

// File: tb/tb_id_stage_reg.sv
// Self-checking bench for id_stage_reg: directed plan steps plus randomized
// traffic checked against a transaction-level model of the stage.
module tb_id_stage_reg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = 32'h0, in_pc = 32'h0;
  logic        in_ready, out_valid, imm_used, illegal;
  logic [31:0] pc_q, instr_q;
  logic [24:0] imm;
  logic [2:0]  immsrc, funct3;
  logic [4:0]  rd, rs1, rs2;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: at most one held transaction.
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0, m_pc = 32'h0;

  logic [6:0] op_tab [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
  string      ty_tab [11] = '{"I", "I", "I", "I", "S", "B",
                              "U", "U", "J", "R", "F"};

  id_stage_reg #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .pc_q(pc_q), .instr_q(instr_q), .imm(imm),
    .immsrc(immsrc), .imm_used(imm_used), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {illegal, imm_used, immsrc} from the instruction-format table.
  function automatic logic [4:0] ref_dec(input logic [31:0] ins);
    for (int i = 0; i < 11; i++) begin
      if (ins[6:0] == op_tab[i]) begin
        if (ty_tab[i] == "I") return 5'b01_000;
        if (ty_tab[i] == "S") return 5'b01_001;
        if (ty_tab[i] == "B") return 5'b01_101;
        if (ty_tab[i] == "U") return 5'b01_010;
        if (ty_tab[i] == "J") return 5'b01_110;
        return 5'b00_000;
      end
    end
    return 5'b10_000;
  endfunction

  task automatic check_outs(input string tag);
    logic [4:0] d;
    chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, m_valid});
    if (m_valid) begin
      d = ref_dec(m_instr);
      chk({tag, ".pc_q"}, pc_q, m_pc);
      chk({tag, ".instr_q"}, instr_q, m_instr);
      chk({tag, ".imm"}, {7'h0, imm}, m_instr >> 7);
      chk({tag, ".rd"}, {27'h0, rd}, (m_instr >> 7) & 32'h1F);
      chk({tag, ".rs1"}, {27'h0, rs1}, (m_instr >> 15) & 32'h1F);
      chk({tag, ".rs2"}, {27'h0, rs2}, (m_instr >> 20) & 32'h1F);
      chk({tag, ".funct3"}, {29'h0, funct3}, (m_instr >> 12) & 32'h7);
      chk({tag, ".dec"}, {27'h0, illegal, imm_used, immsrc}, {27'h0, d});
    end
  endtask

  // One cycle: drive at negedge, check in_ready, clock, update model, check outputs.
  task automatic step(input string tag, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc, input logic fl, input logic ordy);
    bit can_take, take, consumed;
    in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
    can_take = !m_valid || ordy;
    chk({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, can_take});
    consumed = m_valid && ordy;
    take     = iv && can_take && !fl;
    if (consumed || fl) m_valid = 1'b0;
    if (take) begin
      m_valid = 1'b1; m_instr = ins; m_pc = pc;
    end
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".out_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, ".pc_q"}, pc_q, RESET_PC);
    chk({tag, ".instr_q"}, instr_q, 32'h0);
    chk({tag, ".in_ready"}, {31'h0, in_ready}, 32'h1);
    chk({tag, ".decode"}, {imm, immsrc, imm_used, illegal, 1'b0}, 32'h0);
    chk({tag, ".fields"}, {14'h0, rd, rs1, rs2, funct3}, 32'h0);
  endtask

  initial begin
    logic [31:0] sweep [6] = '{32'h00500093, 32'h0020A423, 32'h00208463,
                               32'h12345037, 32'h008000EF, 32'h002081B3};
    logic [31:0] r;
    // Reset held with a valid instruction offered.
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h40; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    step("first", 1'b1, 32'h00500093, 32'h100, 1'b0, 1'b1);

    // Decode sweep at full throughput.
    foreach (sweep[i]) step("sweep", 1'b1, sweep[i], 32'h100, 1'b0, 1'b1);
    step("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("sweep0", 1'b1, sweep[0], 32'h100, 1'b0, 1'b1);
    chk("sweep0.imm_const", {7'h0, imm}, 32'h000A001);
    chk("sweep0.rd_const", {27'h0, rd}, 32'h1);
    step("sweep4", 1'b1, sweep[4], 32'h104, 1'b0, 1'b1);
    chk("sweep4.immsrc_const", {29'h0, immsrc}, 32'h6);

    // Illegal opcode still passes through.
    step("illegal", 1'b1, 32'hFFFFFFFF, 32'h108, 1'b0, 1'b1);
    chk("illegal.flag_const", {30'h0, illegal, out_valid}, 32'h3);

    // Stall: held word stays, new offer waits, then loads exactly once.
    step("stall_ld", 1'b1, 32'h00500093, 32'h200, 1'b0, 1'b1);
    repeat (3) step("stall", 1'b1, 32'h0020A423, 32'h204, 1'b0, 1'b0);
    chk("stall.pc_const", pc_q, 32'h200);
    step("stall_rel", 1'b1, 32'h0020A423, 32'h204, 1'b0, 1'b1);
    step("stall_nodup", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush with consumer ready, then with consumer stalled.
    step("fl_ld", 1'b1, 32'h00208463, 32'h300, 1'b0, 1'b1);
    step("flush_rdy", 1'b1, 32'h12345037, 32'h304, 1'b1, 1'b1);
    step("flush_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("fl_ld2", 1'b1, 32'h008000EF, 32'h308, 1'b0, 1'b1);
    step("flush_stall", 1'b1, 32'h002081B3, 32'h30C, 1'b1, 1'b0);
    step("flush_after2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0)
        r = {r[31:7], op_tab[$urandom_range(0, 10)]};
      step("rand", 1'($urandom_range(0, 3) != 0), r, $urandom,
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Async reset between edges while holding a valid word.
    step("ar_ld", 1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0);
    chk("ar_pre.out_valid", {31'h0, out_valid}, 32'h1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    check_reset_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_post", 1'b1, 32'h00000073, 32'h500, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
